// File: rtl/eer_rl_pkg.sv
// ---------------------------------------------------------------------------
// eer_rl_pkg
// Shared definitions for the EER-RL node logic: packet type codes (also used
// by myNodeInfo), per-type word counts, header bit positions, the TX builder
// state encoding and the snapshot record of node fields.
// ---------------------------------------------------------------------------
package eer_rl_pkg;

  localparam int WORD_W    = 16;  // data word width (14.2 fixed point)
  localparam int SEQ_W     = 7;   // per-node sequence counter width
  localparam int MAX_WORDS = 5;   // longest packet, header included
  localparam int IDX_W     = $clog2(MAX_WORDS);
  localparam int CNT_W     = 4;   // width of the header word-count field

  // Header layout: [15:13] type, [12] role, [11] low_E, [10:4] seq, [3:0] count
  localparam int HDR_TYPE_MSB = 15;
  localparam int HDR_TYPE_LSB = 13;
  localparam int HDR_ROLE_BIT = 12;
  localparam int HDR_LOWE_BIT = 11;
  localparam int HDR_SEQ_MSB  = 10;
  localparam int HDR_SEQ_LSB  = 4;
  localparam int HDR_CNT_MSB  = 3;
  localparam int HDR_CNT_LSB  = 0;

  typedef enum logic [2:0] {
    PKT_HB   = 3'b000,
    PKT_CHE  = 3'b001,
    PKT_JOIN = 3'b010,
    PKT_TS   = 3'b011,
    PKT_DATA = 3'b100
  } pkt_type_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_SEND = 2'd2,
    ST_DONE = 2'd3
  } tx_state_e;

  // Node fields captured at packet start so later input changes cannot
  // disturb a packet already in flight.
  typedef struct packed {
    logic [WORD_W-1:0] node_id;
    logic [WORD_W-1:0] hops;
    logic [WORD_W-1:0] q_value;
    logic [WORD_W-1:0] energy;
    logic [WORD_W-1:0] e_max;
    logic [WORD_W-1:0] e_min;
    logic [WORD_W-1:0] ch_id;
    logic [WORD_W-1:0] timeslot;
  } node_fields_t;

  // Total words (header included) for a type; 0 marks an unsupported type.
  function automatic logic [CNT_W-1:0] pkt_word_count(input logic [2:0] t);
    logic [CNT_W-1:0] cnt;
    case (t)
      PKT_HB:   cnt = CNT_W'(5);
      PKT_CHE:  cnt = CNT_W'(4);
      PKT_JOIN: cnt = CNT_W'(5);
      PKT_TS:   cnt = CNT_W'(4);
      PKT_DATA: cnt = CNT_W'(4);
      default:  cnt = '0;
    endcase
    return cnt;
  endfunction

  function automatic logic [WORD_W-1:0] pkt_header(
    input logic [2:0]       t,
    input logic             role,
    input logic             low_e,
    input logic [SEQ_W-1:0] seq,
    input logic [CNT_W-1:0] cnt
  );
    logic [WORD_W-1:0] h;
    h = '0;
    h[HDR_TYPE_MSB:HDR_TYPE_LSB] = t;
    h[HDR_ROLE_BIT]              = role;
    h[HDR_LOWE_BIT]              = low_e;
    h[HDR_SEQ_MSB:HDR_SEQ_LSB]   = seq;
    h[HDR_CNT_MSB:HDR_CNT_LSB]   = cnt;
    return h;
  endfunction

endpackage

// File: rtl/pkt_tx_builder_if.sv
// ---------------------------------------------------------------------------
// pkt_tx_builder_if
// Word stream from the packet builder to the link-layer TX FIFO.
//   tx_data  : current 16-bit word
//   tx_valid : tx_data valid
//   tx_last  : final word of the packet
//   tx_ready : downstream accepts the word (transfer on valid & ready)
// master = packet builder, slave = TX FIFO / MAC.
// ---------------------------------------------------------------------------
interface pkt_tx_builder_if;

  logic [eer_rl_pkg::WORD_W-1:0] tx_data;
  logic                          tx_valid;
  logic                          tx_last;
  logic                          tx_ready;

  modport master (
    output tx_data,
    output tx_valid,
    output tx_last,
    input  tx_ready
  );

  modport slave (
    input  tx_data,
    input  tx_valid,
    input  tx_last,
    output tx_ready
  );

endinterface

// File: rtl/pkt_tx_builder.sv
// ---------------------------------------------------------------------------
// pkt_tx_builder
// Builds an outgoing EER-RL packet from the node's own state and streams it
// one word per handshake to the radio/MAC TX FIFO.
//   clk, nrst        : clock, synchronous active-high reset
//   en_TX, tx_type   : start pulse (honoured only in IDLE) and packet type
//   myNodeID .. low_E: node fields, snapshotted on an accepted start
//   tx (master)      : tx_data / tx_valid / tx_last out, tx_ready in
//   busy             : packet in progress (LOAD, SEND, DONE)
//   done             : one-cycle pulse after the last word is accepted
//   err_type         : one-cycle pulse after a start with unsupported type
// ---------------------------------------------------------------------------
module pkt_tx_builder
  import eer_rl_pkg::*;
(
  input  logic              clk,
  input  logic              nrst,
  input  logic              en_TX,
  input  logic [2:0]        tx_type,
  input  logic [WORD_W-1:0] myNodeID,
  input  logic [WORD_W-1:0] hopsFromSink,
  input  logic [WORD_W-1:0] myQValue,
  input  logic [WORD_W-1:0] energy,
  input  logic [WORD_W-1:0] e_max,
  input  logic [WORD_W-1:0] e_min,
  input  logic [WORD_W-1:0] ch_ID,
  input  logic [WORD_W-1:0] timeslot,
  input  logic              role,
  input  logic              low_E,
  pkt_tx_builder_if.master  tx,
  output logic              busy,
  output logic              done,
  output logic              err_type
);

  tx_state_e        r_state;
  tx_state_e        w_state_next;
  logic [2:0]       r_type;
  logic             r_role;
  logic             r_low_e;
  node_fields_t     r_fields;
  logic [SEQ_W-1:0] r_seq;
  logic [IDX_W-1:0] r_idx;
  logic [CNT_W-1:0] r_count;
  logic [WORD_W-1:0] r_hdr;
  logic             r_err_type;

  logic             w_start;
  logic             w_type_ok;
  logic             w_xfer;
  logic             w_last;

  // Word selection for a given type/index. Words 0 and 1 are common to all
  // types; the rest depend on the layout of the type.
  function automatic logic [WORD_W-1:0] pkt_word(
    input logic [2:0]        t,
    input logic [IDX_W-1:0]  idx,
    input logic [WORD_W-1:0] hdr,
    input node_fields_t      f
  );
    logic [WORD_W-1:0] w;
    w = '0;
    if (idx == IDX_W'(0)) begin
      w = hdr;
    end else if (idx == IDX_W'(1)) begin
      w = f.node_id;
    end else begin
      case (t)
        PKT_HB: begin
          case (idx)
            IDX_W'(2): w = f.hops;
            IDX_W'(3): w = f.e_max;
            IDX_W'(4): w = f.e_min;
            default:   w = '0;
          endcase
        end
        PKT_CHE: begin
          case (idx)
            IDX_W'(2): w = f.q_value;
            IDX_W'(3): w = f.hops;
            default:   w = '0;
          endcase
        end
        PKT_JOIN: begin
          case (idx)
            IDX_W'(2): w = f.ch_id;
            IDX_W'(3): w = f.q_value;
            IDX_W'(4): w = f.energy;
            default:   w = '0;
          endcase
        end
        PKT_TS: begin
          case (idx)
            IDX_W'(2): w = f.ch_id;
            IDX_W'(3): w = f.timeslot;
            default:   w = '0;
          endcase
        end
        PKT_DATA: begin
          case (idx)
            IDX_W'(2): w = f.ch_id;
            IDX_W'(3): w = f.energy;
            default:   w = '0;
          endcase
        end
        default: w = '0;
      endcase
    end
    return w;
  endfunction

  assign w_start   = en_TX && (r_state == ST_IDLE);
  assign w_type_ok = (pkt_word_count(tx_type) != '0);
  assign w_xfer    = (r_state == ST_SEND) && tx.tx_ready;
  assign w_last    = (CNT_W'(r_idx) == (r_count - CNT_W'(1)));

  // Next state and outputs
  always_comb begin
    w_state_next = r_state;
    tx.tx_valid  = 1'b0;
    tx.tx_last   = 1'b0;
    tx.tx_data   = '0;
    busy         = (r_state != ST_IDLE);
    done         = 1'b0;
    err_type     = r_err_type;
    case (r_state)
      ST_IDLE: begin
        if (w_start && w_type_ok) begin
          w_state_next = ST_LOAD;
        end
      end
      ST_LOAD: begin
        w_state_next = ST_SEND;
      end
      ST_SEND: begin
        tx.tx_valid = 1'b1;
        tx.tx_last  = w_last;
        tx.tx_data  = pkt_word(r_type, r_idx, r_hdr, r_fields);
        if (w_xfer && w_last) begin
          w_state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        done         = 1'b1;
        w_state_next = ST_IDLE;
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (nrst) begin
      r_state    <= ST_IDLE;
      r_type     <= '0;
      r_role     <= 1'b0;
      r_low_e    <= 1'b0;
      r_fields   <= '0;
      r_seq      <= '0;
      r_idx      <= '0;
      r_count    <= '0;
      r_hdr      <= '0;
      r_err_type <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_err_type <= w_start && !w_type_ok;

      if (w_start && w_type_ok) begin
        r_type            <= tx_type;
        r_role            <= role;
        r_low_e           <= low_E;
        r_count           <= pkt_word_count(tx_type);
        r_fields.node_id  <= myNodeID;
        r_fields.hops     <= hopsFromSink;
        r_fields.q_value  <= myQValue;
        r_fields.energy   <= energy;
        r_fields.e_max    <= e_max;
        r_fields.e_min    <= e_min;
        r_fields.ch_id    <= ch_ID;
        r_fields.timeslot <= timeslot;
      end

      if (r_state == ST_LOAD) begin
        r_hdr <= pkt_header(r_type, r_role, r_low_e, r_seq, r_count);
        r_idx <= '0;
      end

      // Index only moves on an accepted non-last word, so data/last hold
      // steady through downstream stalls.
      if (w_xfer && !w_last) begin
        r_idx <= r_idx + IDX_W'(1);
      end

      // Sequence wraps naturally at 2**SEQ_W.
      if (r_state == ST_DONE) begin
        r_seq <= r_seq + SEQ_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_pkt_tx_builder.sv
// ---------------------------------------------------------------------------
// tb_pkt_tx_builder
// Directed self-checking bench for pkt_tx_builder with hand-computed words.
// ---------------------------------------------------------------------------
module tb_pkt_tx_builder;
  import eer_rl_pkg::*;

  logic        clk = 1'b0;
  logic        nrst;
  logic        en_TX;
  logic [2:0]  tx_type;
  logic [15:0] myNodeID, hopsFromSink, myQValue, energy;
  logic [15:0] e_max, e_min, ch_ID, timeslot;
  logic        role, low_E;
  logic        busy, done, err_type;

  int n_checks = 0;
  int n_pass   = 0;

  logic [15:0] exp_words [5];

  pkt_tx_builder_if u_if ();

  pkt_tx_builder u_dut (
    .clk          (clk),
    .nrst         (nrst),
    .en_TX        (en_TX),
    .tx_type      (tx_type),
    .myNodeID     (myNodeID),
    .hopsFromSink (hopsFromSink),
    .myQValue     (myQValue),
    .energy       (energy),
    .e_max        (e_max),
    .e_min        (e_min),
    .ch_ID        (ch_ID),
    .timeslot     (timeslot),
    .role         (role),
    .low_E        (low_E),
    .tx           (u_if),
    .busy         (busy),
    .done         (done),
    .err_type     (err_type)
  );

  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_fields(input logic [15:0] id, input logic [15:0] hops,
                            input logic [15:0] q, input logic [15:0] en,
                            input logic [15:0] emax, input logic [15:0] emin,
                            input logic [15:0] ch, input logic [15:0] ts,
                            input logic rl, input logic le);
    myNodeID = id; hopsFromSink = hops; myQValue = q; energy = en;
    e_max = emax; e_min = emin; ch_ID = ch; timeslot = ts;
    role = rl; low_E = le;
  endtask

  // Start a packet and collect it against exp_words.
  // ready_mode 0: tx_ready held high; 1: pattern 1,0,0 repeating.
  // inject: raise en_TX (bad then good type) while the packet is in SEND.
  task automatic run_pkt(input logic [2:0] t, input int n, input int ready_mode, input bit inject);
    int          k;
    int          cyc;
    bit          held;
    logic [15:0] held_data;
    logic        held_last;
    logic        rdy;
    en_TX = 1'b1;
    tx_type = t;
    tick();
    en_TX = 1'b0;
    check_value("load_busy", busy, 1);
    check_value("load_valid", u_if.tx_valid, 0);
    tick();
    check_value("first_valid", u_if.tx_valid, 1);
    // Scramble inputs: the packet must come from the snapshot.
    set_fields(16'hDEAD, 16'hDEAD, 16'hDEAD, 16'hDEAD, 16'hDEAD,
               16'hDEAD, 16'hDEAD, 16'hDEAD, ~role, ~low_E);
    k = 0; cyc = 0; held = 1'b0; held_data = '0; held_last = 1'b0;
    while (k < n && cyc < 200) begin
      if (held) begin
        check_value("stall_data", u_if.tx_data, held_data);
        check_value("stall_last", u_if.tx_last, held_last);
        check_value("stall_valid", u_if.tx_valid, 1);
      end
      rdy = (ready_mode == 0) ? 1'b1 : ((cyc % 3) == 0);
      u_if.tx_ready = rdy;
      if (inject) begin
        if (cyc == 1) begin en_TX = 1'b1; tx_type = 3'b110; end
        if (cyc == 2) tx_type = PKT_HB;
        if (cyc == 3) en_TX = 1'b0;
      end
      if (rdy) begin
        check_value("word_valid", u_if.tx_valid, 1);
        check_value("word_data", u_if.tx_data, exp_words[k]);
        check_value("word_last", u_if.tx_last, (k == n - 1) ? 1 : 0);
        k++;
        held = 1'b0;
      end else begin
        held = 1'b1;
        held_data = u_if.tx_data;
        held_last = u_if.tx_last;
      end
      tick();
      cyc++;
      if (inject) check_value("busy_no_err", err_type, 0);
    end
    en_TX = 1'b0;
    check_value("word_count", k, n);
    check_value("done_pulse", done, 1);
    check_value("done_valid", u_if.tx_valid, 0);
    check_value("done_busy", busy, 1);
    tick();
    check_value("idle_done", done, 0);
    check_value("idle_busy", busy, 0);
    check_value("idle_valid", u_if.tx_valid, 0);
    $display("pkt type=%0d words=%0d hdr=%h cycles=%0d", t, k, exp_words[0], cyc);
  endtask

  initial begin
    nrst = 1'b1; en_TX = 1'b0; tx_type = '0; u_if.tx_ready = 1'b0;
    set_fields(16'h0005, 16'h0001, 16'h0000, 16'h0000, 16'h8000,
               16'h4000, 16'h0000, 16'h0000, 1'b0, 1'b0);
    tick();
    tick();
    check_value("rst_valid", u_if.tx_valid, 0);
    check_value("rst_data", u_if.tx_data, 0);
    check_value("rst_last", u_if.tx_last, 0);
    check_value("rst_busy", busy, 0);
    check_value("rst_done", done, 0);
    check_value("rst_err", err_type, 0);
    nrst = 1'b0;
    tick();

    // HB, seq 0
    exp_words = '{16'h0005, 16'h0005, 16'h0001, 16'h8000, 16'h4000};
    run_pkt(PKT_HB, 5, 0, 1'b0);

    // CHE, role=1, seq 1
    set_fields(16'h0005, 16'h0001, 16'h3333, 16'h0000, 16'h0000,
               16'h0000, 16'h0000, 16'h0000, 1'b1, 1'b0);
    exp_words = '{16'h3014, 16'h0005, 16'h3333, 16'h0001, 16'h0000};
    run_pkt(PKT_CHE, 4, 0, 1'b0);

    // JOIN, low_E=1, seq 2, stalling downstream
    set_fields(16'h0005, 16'h0001, 16'h3333, 16'h7000, 16'h0000,
               16'h0000, 16'h0012, 16'h0000, 1'b0, 1'b1);
    exp_words = '{16'h4825, 16'h0005, 16'h0012, 16'h3333, 16'h7000};
    run_pkt(PKT_JOIN, 5, 1, 1'b0);

    // Unsupported type in IDLE
    en_TX = 1'b1; tx_type = 3'b110;
    tick();
    en_TX = 1'b0;
    check_value("err_pulse", err_type, 1);
    check_value("err_busy", busy, 0);
    check_value("err_valid", u_if.tx_valid, 0);
    tick();
    check_value("err_clear", err_type, 0);
    check_value("err_idle_busy", busy, 0);

    // TS, seq 3, en_TX raised mid-packet must be ignored
    set_fields(16'h00A1, 16'h0000, 16'h0000, 16'h0000, 16'h0000,
               16'h0000, 16'h0012, 16'h0007, 1'b0, 1'b0);
    exp_words = '{16'h6034, 16'h00A1, 16'h0012, 16'h0007, 16'h0000};
    run_pkt(PKT_TS, 4, 0, 1'b1);

    // DATA packets seq 4..126, then 127 and the wrap to 0
    for (int s = 4; s < 127; s++) begin
      set_fields(16'h0005, 16'h0000, 16'h0000, 16'h1234, 16'h0000,
                 16'h0000, 16'h0012, 16'h0000, 1'b0, 1'b0);
      exp_words = '{16'h8004 | (16'(s) << 4), 16'h0005, 16'h0012, 16'h1234, 16'h0000};
      run_pkt(PKT_DATA, 4, 0, 1'b0);
    end
    set_fields(16'h0005, 16'h0000, 16'h0000, 16'h1234, 16'h0000,
               16'h0000, 16'h0012, 16'h0000, 1'b0, 1'b0);
    exp_words = '{16'h87F4, 16'h0005, 16'h0012, 16'h1234, 16'h0000};
    run_pkt(PKT_DATA, 4, 0, 1'b0);
    set_fields(16'h0005, 16'h0000, 16'h0000, 16'h1234, 16'h0000,
               16'h0000, 16'h0012, 16'h0000, 1'b0, 1'b0);
    exp_words = '{16'h8004, 16'h0005, 16'h0012, 16'h1234, 16'h0000};
    run_pkt(PKT_DATA, 4, 0, 1'b0);

    // Reset in the middle of an HB packet (seq 1) at word 2
    set_fields(16'h0005, 16'h0001, 16'h0000, 16'h0000, 16'h8000,
               16'h4000, 16'h0000, 16'h0000, 1'b0, 1'b0);
    u_if.tx_ready = 1'b1;
    en_TX = 1'b1; tx_type = PKT_HB;
    tick();
    en_TX = 1'b0;
    tick();
    check_value("mid_hdr", u_if.tx_data, 16'h0015);
    tick();
    check_value("mid_word1", u_if.tx_data, 16'h0005);
    tick();
    check_value("mid_word2", u_if.tx_data, 16'h0001);
    nrst = 1'b1;
    tick();
    nrst = 1'b0;
    check_value("mid_rst_valid", u_if.tx_valid, 0);
    check_value("mid_rst_busy", busy, 0);
    check_value("mid_rst_done", done, 0);
    $display("pkt type=0 aborted by reset at word 2");
    tick();

    // Fresh packet after reset: seq back to 0, starts at header
    exp_words = '{16'h0005, 16'h0005, 16'h0001, 16'h8000, 16'h4000};
    run_pkt(PKT_HB, 5, 0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pkt_tx_builder.md
Name: pkt_tx_builder

Overview:
Transmit-side counterpart of myNodeInfo: builds an outgoing EER-RL packet from the node's own state and streams it one 16-bit word per handshake to the radio/MAC interface. It snapshots node fields on a start pulse, emits a typed header followed by type-dependent fields, and keeps a wrapping per-node sequence number. It sits between myNodeInfo (field source) and the link-layer TX FIFO.

Parameters:
WORD_W, 16, data word width (14.2 fixed-point energy/Q values)
SEQ_W, 7, sequence counter width
MAX_WORDS, 5, longest packet in words (header included)

Ports:
clk  in  1  system clock, all logic on rising edge
nrst  in  1  synchronous, active-high reset (1 = reset)
en_TX  in  1  start pulse; sampled only in IDLE
tx_type  in  3  packet type to build
myNodeID  in  16  source ID
hopsFromSink  in  16  own hop count
myQValue  in  16  own Q value
energy  in  16  own residual energy
e_max  in  16  forwarded max energy
e_min  in  16  forwarded min energy
ch_ID  in  16  cluster-head / destination ID
timeslot  in  16  assigned timeslot
role  in  1  1 = cluster head
low_E  in  1  low-energy flag
tx_data  out  16  current word
tx_valid  out  1  tx_data valid
tx_ready  in  1  downstream accepts word
tx_last  out  1  final word of packet
busy  out  1  packet in progress
done  out  1  one-cycle pulse after last word accepted
err_type  out  1  one-cycle pulse on start with unsupported type

Behaviour:
- Reset (nrst=1 at edge): state IDLE; tx_data=0, tx_valid=0, tx_last=0, busy=0, done=0, err_type=0, seq=0, word index=0. Reset mid-packet discards the packet immediately; no partial completion, seq unchanged from 0.
- Packet layouts (word 0 = header, words in this order):
  000 HB: hdr, myNodeID, hopsFromSink, e_max, e_min (5)
  001 CHE: hdr, myNodeID, myQValue, hopsFromSink (4)
  010 JOIN: hdr, myNodeID, ch_ID, myQValue, energy (5)
  011 TS: hdr, myNodeID, ch_ID, timeslot (4)
  100 DATA: hdr, myNodeID, ch_ID, energy (4)
  101..111: unsupported.
- Header: [15:13]=tx_type, [12]=role, [11]=low_E, [10:4]=seq, [3:0]=word count.
- States: IDLE -> LOAD -> SEND -> DONE -> IDLE.
  IDLE: en_TX=1 with valid type -> LOAD, snapshot all field inputs into registers, busy=1 next cycle. Invalid type -> err_type pulse next cycle, stay IDLE.
  LOAD: one cycle; build header, index=0. -> SEND.
  SEND: tx_valid=1, tx_data=word[index]; tx_last=1 when index=count-1. Word transfers on tx_valid & tx_ready. On transfer of non-last word, index+1 next cycle. On last transfer -> DONE.
  DONE: tx_valid=0, done=1 for exactly one cycle, seq increments (wraps 127->0), busy=0 next cycle -> IDLE.
- Latency: en_TX at edge N -> first word valid after edge N+2; with tx_ready tied high a 5-word packet occupies 5 consecutive valid cycles, done at the cycle following the last.
- Handshake: while tx_valid & !tx_ready, tx_data/tx_last hold stable; tx_valid never drops before transfer.
- en_TX while busy (LOAD/SEND/DONE): ignored, no queueing, no err.
- Field inputs changing after snapshot do not affect the packet in flight.
- Back-to-back: en_TX accepted in IDLE the cycle after DONE.

Decomposition:
- Shared package eer_rl_pkg: packet type codes (PKT_HB, PKT_CHE, PKT_JOIN, PKT_TS, PKT_DATA), per-type word counts, header bit positions, state encoding. myNodeInfo uses the same type codes.
- No sub-module required; the per-type word mux is a function in the block.

Test Plan:
- Reset, then en_TX with tx_type=000, myNodeID=0x0005, hopsFromSink=1, e_max=0x8000, e_min=0x4000, role=0, low_E=0, tx_ready=1 -> words 0x0005,0x0005,0x0001,0x8000,0x4000 (hdr = type0, seq0, count5), tx_last on word 5, done one cycle after.
- CHE with role=1, myQValue=0x3333, second packet (seq=1) -> hdr 0x3014, then ID, 0x3333, hops; 4 words.
- JOIN with tx_ready toggling 1,0,0,1,... -> each word held stable across stalls, exactly 5 transfers, order intact.
- en_TX with tx_type=110 -> err_type pulse, busy stays 0, no tx_valid; en_TX during SEND -> ignored, packet unchanged.
- 128 completed packets -> header seq wraps 127 -> 0.
- nrst=1 mid-SEND at word 2 -> next cycle tx_valid=0, busy=0, seq=0; fresh packet afterwards starts at header.
